// File: rtl/mul_if.sv
// Issue/result bundle between the execute stage and the iterative multiplier.
// The execute stage drives the request side (master); the multiplier owns busy/done/result (slave).
interface mul_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/mul_unit.sv
// Radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Operands are multiplied as magnitudes; the product sign is restored on the last add.
module mul_unit #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  mul_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [2*XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              neg_reg, neg_next;
  logic [1:0]        op_reg, op_next;
  logic [XLEN-1:0]   result_reg, result_next;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] sum, prod;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH
  assign a_signed = (bus.op == 2'b01) || (bus.op == 2'b10);
  assign b_signed = (bus.op == 2'b01);
  assign a_neg    = a_signed && bus.rs1[XLEN-1];
  assign b_neg    = b_signed && bus.rs2[XLEN-1];
  assign a_abs    = a_neg ? -bus.rs1 : bus.rs1;
  assign b_abs    = b_neg ? -bus.rs2 : bus.rs2;

  assign sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign prod = neg_reg ? -sum : sum;

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    neg_next    = neg_reg;
    op_next     = op_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.kill) begin
          state_next  = RUN;
          acc_next    = '0;
          mcand_next  = {{XLEN{1'b0}}, a_abs};
          mplier_next = b_abs;
          count_next  = '0;
          neg_next    = a_neg ^ b_neg;
          op_next     = bus.op;
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_next = IDLE;
        end else begin
          acc_next    = sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg + CW'(1);
          // The final partial product is folded straight into the result.
          if (count_reg == CW'(XLEN-1)) begin
            state_next  = DONE;
            result_next = (op_reg == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      op_reg     <= 2'b00;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
      neg_reg    <= neg_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit: product table, latency, ignored start, kill, reset, back-to-back issue.
module tb_mul_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mul_if #(.XLEN(32)) m ();

  mul_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Independent 64-bit reference: sign/zero-extend and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    y = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    m.start = 1'b1; m.op = op; m.rs1 = a; m.rs2 = b;
    @(posedge clk); #1;
    m.start = 1'b0;
    check({name, " busy@1"}, 32'(m.busy), 32'd1);
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (m.done) begin lat = n; break; end
    end
    res = m.result;
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " result"}, res, exp);
    @(posedge clk); #1;
    check({name, " done_pulse_end"}, {30'h0, m.done, m.busy}, 32'd0);
    check({name, " result_held"}, m.result, res);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    logic [1:0]  rop;
    int          dn, c0, dcyc[3];

    vecs[0]  = '{"mul_7_neg3",       2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulh_min_min",     2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{"mulhu_min_min",    2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3]  = '{"mul_min_min",      2'b00, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[4]  = '{"mulhsu_m1_max",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{"mulhu_max_max",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[6]  = '{"mulh_m1_m1",       2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[7]  = '{"mul_m1_m1",        2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[8]  = '{"mul_3_4",          2'b00, 32'h00000003, 32'h00000004, 32'h0000000C};
    vecs[9]  = '{"mulh_zero",        2'b01, 32'h00000000, 32'h89ABCDEF, 32'h00000000};
    vecs[10] = '{"mulhsu_min_max",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{"mulh_maxpos_sq",   2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[12] = '{"mulh_neg2_3",      2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[13] = '{"mulhu_2p16_sq",    2'b11, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[14] = '{"mul_shift",        2'b00, 32'h12345678, 32'h00000010, 32'h23456780};

    m.start = 1'b0; m.kill = 1'b0; m.op = 2'b00; m.rs1 = '0; m.rs2 = '0;
    #1;
    check("reset_state", {29'h0, m.busy, m.done, |m.result}, 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
      if (i < 4) ra = ra | 32'h80000000;
      if (i >= 4 && i < 8) rb = rb | 32'h80000000;
      rexp = ref_mul(rop, ra, rb);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rexp);
    end

    // start pulsed mid-operation with different operands must be ignored
    m.start = 1'b1; m.op = 2'b00; m.rs1 = 32'd5; m.rs2 = 32'd6;
    @(posedge clk); #1;
    m.start = 1'b0;
    dn = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin m.start = 1'b1; m.rs1 = 32'd100; m.rs2 = 32'd100; m.op = 2'b11; end
      else m.start = 1'b0;
      if (m.done) begin dn = n; break; end
    end
    check("ignored_start latency", 32'(dn), 32'd33);
    check("ignored_start result", m.result, 32'd30);
    @(posedge clk); #1;

    // kill in RUN: back to idle next edge, no done, result untouched
    m.start = 1'b1; m.op = 2'b00; m.rs1 = 32'd9; m.rs2 = 32'd9;
    @(posedge clk); #1;
    m.start = 1'b0;
    for (int n = 2; n <= 10; n++) begin @(posedge clk); #1; end
    m.kill = 1'b1;
    @(posedge clk); #1;
    m.kill = 1'b0;
    check("kill busy@11", 32'(m.busy), 32'd0);
    dn = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (m.done || m.busy) dn++; end
    check("kill no_done", 32'(dn), 32'd0);
    check("kill result_kept", m.result, 32'd30);

    // kill and start together in IDLE: nothing accepted
    m.start = 1'b1; m.kill = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0; m.kill = 1'b0;
    check("kill_beats_start busy", 32'(m.busy), 32'd0);

    // asynchronous reset mid-operation
    m.start = 1'b1; m.op = 2'b00; m.rs1 = 32'd11; m.rs2 = 32'd13;
    @(posedge clk); #1;
    m.start = 1'b0;
    for (int n = 2; n <= 20; n++) begin @(posedge clk); #1; end
    check("pre_reset busy", 32'(m.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset outputs", {29'h0, m.busy, m.done, |m.result}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset idle", 32'(m.busy), 32'd0);
    run_op("after_reset_mul_3_4", 2'b00, 32'd3, 32'd4, 32'd12);

    // start held high: accepts every XLEN+2 cycles
    m.start = 1'b1; m.op = 2'b01; m.rs1 = 32'hFFFFFFF9; m.rs2 = 32'h00000003;
    dn = 0; c0 = 0;
    for (int n = 1; n <= 120 && dn < 3; n++) begin
      @(posedge clk); #1;
      if (m.done) begin
        dcyc[dn] = n;
        check($sformatf("b2b result%0d", dn), m.result, 32'hFFFFFFFF);
        dn++;
      end
    end
    m.start = 1'b0;
    check("b2b done_count", 32'(dn), 32'd3);
    if (dn == 3) begin
      check("b2b first", 32'(dcyc[0]), 32'd33);
      check("b2b interval1", 32'(dcyc[1] - dcyc[0]), 32'd34);
      check("b2b interval2", 32'(dcyc[2] - dcyc[1]), 32'd34);
    end
    for (int n = 0; n < 3; n++) begin @(posedge clk); #1; if (m.busy) c0++; end
    check("b2b stop idle", 32'(c0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
